mmu_tlb: RTL and testbench

- Joint TLB sitting directly downstream of the CP0–TLB relay stage.
- Consumes the relay's registered CP0 snapshot (index, entryhi, entrylo0/1) and the tlbp/tlbr/tlbwi strobes; returns registered op results one cycle later.
- Translates instruction and data virtual addresses combinationally and raises refill/invalid/modify flags in the same cycle, so the relay samples them together with the faulting address.

---
 rtl/mmu_tlb_if.sv | 45 ++++
 rtl/mmu_tlb.sv | 128 ++++++++++++
 tb/tb_mmu_tlb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_tlb_if.sv
// Relay <-> TLB bundle: CP0 op channel plus the instruction and data translation ports.
// The master side is the CP0-TLB relay / pipeline, and the slave side is the TLB.
interface mmu_tlb_if;
  logic [31:0] cp0_index_r2t;
  logic [31:0] cp0_entryhi_r2t;
  logic [31:0] cp0_entrylo0_r2t;
  logic [31:0] cp0_entrylo1_r2t;
  logic        op_tlbp_r2t;
  logic        op_tlbr_r2t;
  logic        op_tlbwi_r2t;
  logic [31:0] tlb_index_t2r;
  logic [31:0] tlb_entryhi_t2r;
  logic [31:0] tlb_entrylo0_t2r;
  logic [31:0] tlb_entrylo1_t2r;
  logic        inst_en;
  logic [31:0] inst_vaddr;
  logic [31:0] inst_paddr;
  logic        data_en;
  logic        data_wen;
  logic [31:0] data_vaddr;
  logic [31:0] data_paddr;
  logic        i_refill_t2r;
  logic        i_invalid_t2r;
  logic        d_refill_t2r;
  logic        d_invalid_t2r;
  logic        d_modify_t2r;

  modport master (
    output cp0_index_r2t, cp0_entryhi_r2t, cp0_entrylo0_r2t, cp0_entrylo1_r2t,
    output op_tlbp_r2t, op_tlbr_r2t, op_tlbwi_r2t,
    output inst_en, inst_vaddr, data_en, data_wen, data_vaddr,
    input  tlb_index_t2r, tlb_entryhi_t2r, tlb_entrylo0_t2r, tlb_entrylo1_t2r,
    input  inst_paddr, data_paddr,
    input  i_refill_t2r, i_invalid_t2r, d_refill_t2r, d_invalid_t2r, d_modify_t2r
  );

  modport slave (
    input  cp0_index_r2t, cp0_entryhi_r2t, cp0_entrylo0_r2t, cp0_entrylo1_r2t,
    input  op_tlbp_r2t, op_tlbr_r2t, op_tlbwi_r2t,
    input  inst_en, inst_vaddr, data_en, data_wen, data_vaddr,
    output tlb_index_t2r, tlb_entryhi_t2r, tlb_entrylo0_t2r, tlb_entrylo1_t2r,
    output inst_paddr, data_paddr,
    output i_refill_t2r, i_invalid_t2r, d_refill_t2r, d_invalid_t2r, d_modify_t2r
  );
endinterface

// File: rtl/mmu_tlb.sv
// Joint TLB: registered tlbp/tlbr/tlbwi results, plus combinational instruction and data
// translation with same-cycle refill/invalid/modify flags.
module mmu_tlb #(
  parameter int TLBNUM  = 16,
  parameter int INDEX_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  mmu_tlb_if.slave   bus
);

  typedef struct packed {
    logic               hit;
    logic [INDEX_W-1:0] idx;
  } match_t;

  logic [18:0] tlb_vpn2 [TLBNUM];
  logic [7:0]  tlb_asid [TLBNUM];
  logic        tlb_g    [TLBNUM];
  logic [19:0] tlb_pfn0 [TLBNUM];
  logic [2:0]  tlb_c0   [TLBNUM];
  logic        tlb_d0   [TLBNUM];
  logic        tlb_v0   [TLBNUM];
  logic [19:0] tlb_pfn1 [TLBNUM];
  logic [2:0]  tlb_c1   [TLBNUM];
  logic        tlb_d1   [TLBNUM];
  logic        tlb_v1   [TLBNUM];

  logic [7:0]         cur_asid;
  logic [INDEX_W-1:0] op_idx;
  match_t             i_m, d_m, p_m;
  logic               unused_bits;

  assign cur_asid = bus.cp0_entryhi_r2t[7:0];
  assign op_idx   = bus.cp0_index_r2t[INDEX_W-1:0];
  assign unused_bits = ^{bus.cp0_index_r2t[31:INDEX_W], bus.cp0_entryhi_r2t[12:8],
                         bus.cp0_entrylo0_r2t[31:26], bus.cp0_entrylo1_r2t[31:26]};

  // Scanning from the top down leaves the lowest matching index in the result.
  function automatic match_t lookup(input logic [18:0] vpn2, input logic [7:0] asid);
    match_t m;
    m = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (tlb_vpn2[i] == vpn2 && (tlb_g[i] || tlb_asid[i] == asid)) begin
        m.hit = 1'b1;
        m.idx = INDEX_W'(i);
      end
    end
    return m;
  endfunction

  always_comb begin
    i_m = lookup(bus.inst_vaddr[31:13], cur_asid);
    d_m = lookup(bus.data_vaddr[31:13], cur_asid);
    p_m = lookup(bus.cp0_entryhi_r2t[31:13], cur_asid);
  end

  logic        i_mapped, i_v;
  logic [19:0] i_pfn;
  logic        d_mapped, d_v, d_d;
  logic [19:0] d_pfn;

  assign i_mapped = (bus.inst_vaddr[31:30] != 2'b10);
  assign i_pfn    = bus.inst_vaddr[12] ? tlb_pfn1[i_m.idx] : tlb_pfn0[i_m.idx];
  assign i_v      = bus.inst_vaddr[12] ? tlb_v1[i_m.idx]   : tlb_v0[i_m.idx];

  assign d_mapped = (bus.data_vaddr[31:30] != 2'b10);
  assign d_pfn    = bus.data_vaddr[12] ? tlb_pfn1[d_m.idx] : tlb_pfn0[d_m.idx];
  assign d_v      = bus.data_vaddr[12] ? tlb_v1[d_m.idx]   : tlb_v0[d_m.idx];
  assign d_d      = bus.data_vaddr[12] ? tlb_d1[d_m.idx]   : tlb_d0[d_m.idx];

  assign bus.inst_paddr = !i_mapped ? {3'b000, bus.inst_vaddr[28:0]} :
                          i_m.hit   ? {i_pfn, bus.inst_vaddr[11:0]} :
                                      {20'b0, bus.inst_vaddr[11:0]};
  assign bus.data_paddr = !d_mapped ? {3'b000, bus.data_vaddr[28:0]} :
                          d_m.hit   ? {d_pfn, bus.data_vaddr[11:0]} :
                                      {20'b0, bus.data_vaddr[11:0]};

  assign bus.i_refill_t2r  = bus.inst_en & i_mapped & ~i_m.hit;
  assign bus.i_invalid_t2r = bus.inst_en & i_mapped &  i_m.hit & ~i_v;
  assign bus.d_refill_t2r  = bus.data_en & d_mapped & ~d_m.hit;
  assign bus.d_invalid_t2r = bus.data_en & d_mapped &  d_m.hit & ~d_v;
  assign bus.d_modify_t2r  = bus.data_en & d_mapped &  d_m.hit & d_v & ~d_d & bus.data_wen;

  // Ops resolve tlbwi > tlbr > tlbp; translation above still sees the pre-write contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TLBNUM; i++) begin
        tlb_vpn2[i] <= '0;
        tlb_asid[i] <= '0;
        tlb_g[i]    <= 1'b0;
        tlb_pfn0[i] <= '0;
        tlb_c0[i]   <= '0;
        tlb_d0[i]   <= 1'b0;
        tlb_v0[i]   <= 1'b0;
        tlb_pfn1[i] <= '0;
        tlb_c1[i]   <= '0;
        tlb_d1[i]   <= 1'b0;
        tlb_v1[i]   <= 1'b0;
      end
      bus.tlb_index_t2r    <= '0;
      bus.tlb_entryhi_t2r  <= '0;
      bus.tlb_entrylo0_t2r <= '0;
      bus.tlb_entrylo1_t2r <= '0;
    end else if (bus.op_tlbwi_r2t) begin
      tlb_vpn2[op_idx] <= bus.cp0_entryhi_r2t[31:13];
      tlb_asid[op_idx] <= bus.cp0_entryhi_r2t[7:0];
      tlb_g[op_idx]    <= bus.cp0_entrylo0_r2t[0] & bus.cp0_entrylo1_r2t[0];
      tlb_pfn0[op_idx] <= bus.cp0_entrylo0_r2t[25:6];
      tlb_c0[op_idx]   <= bus.cp0_entrylo0_r2t[5:3];
      tlb_d0[op_idx]   <= bus.cp0_entrylo0_r2t[2];
      tlb_v0[op_idx]   <= bus.cp0_entrylo0_r2t[1];
      tlb_pfn1[op_idx] <= bus.cp0_entrylo1_r2t[25:6];
      tlb_c1[op_idx]   <= bus.cp0_entrylo1_r2t[5:3];
      tlb_d1[op_idx]   <= bus.cp0_entrylo1_r2t[2];
      tlb_v1[op_idx]   <= bus.cp0_entrylo1_r2t[1];
    end else if (bus.op_tlbr_r2t) begin
      bus.tlb_entryhi_t2r  <= {tlb_vpn2[op_idx], 5'b0, tlb_asid[op_idx]};
      bus.tlb_entrylo0_t2r <= {6'b0, tlb_pfn0[op_idx], tlb_c0[op_idx], tlb_d0[op_idx],
                               tlb_v0[op_idx], tlb_g[op_idx]};
      bus.tlb_entrylo1_t2r <= {6'b0, tlb_pfn1[op_idx], tlb_c1[op_idx], tlb_d1[op_idx],
                               tlb_v1[op_idx], tlb_g[op_idx]};
    end else if (bus.op_tlbp_r2t) begin
      bus.tlb_index_t2r <= p_m.hit ? 32'(p_m.idx) : 32'h8000_0000;
    end
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb: directed walk through the main scenarios, then
// randomized ops and translations compared against an entry-list reference model.
module tb_mmu_tlb;
  localparam int TLBNUM  = 16;
  localparam int INDEX_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mmu_tlb_if bus ();

  mmu_tlb #(.TLBNUM(TLBNUM), .INDEX_W(INDEX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: each entry keeps the raw CP0 words it was written with.
  logic [18:0] m_vpn2 [TLBNUM];
  logic [7:0]  m_asid [TLBNUM];
  logic        m_g    [TLBNUM];
  logic [31:0] m_lo0  [TLBNUM];
  logic [31:0] m_lo1  [TLBNUM];
  logic [31:0] exp_index, exp_hi, exp_lo0, exp_lo1;

  function automatic void model_reset();
    for (int i = 0; i < TLBNUM; i++) begin
      m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_lo0[i] = '0; m_lo1[i] = '0;
    end
    exp_index = '0; exp_hi = '0; exp_lo0 = '0; exp_lo1 = '0;
  endfunction

  function automatic int model_lookup(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int i = 0; i < TLBNUM; i++)
      if (m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid)) return i;
    return -1;
  endfunction

  function automatic void model_xlate(input logic [31:0] va, input logic en, input logic wen,
                                      output logic [31:0] pa, output logic refill,
                                      output logic invalid, output logic modify);
    int hit;
    logic [31:0] lo;
    refill = 1'b0; invalid = 1'b0; modify = 1'b0;
    if (va[31:30] == 2'b10) begin
      pa = {3'b000, va[28:0]};
      return;
    end
    hit = model_lookup(va[31:13], bus.cp0_entryhi_r2t[7:0]);
    if (hit < 0) begin
      pa = {20'b0, va[11:0]};
      refill = en;
    end else begin
      lo = va[12] ? m_lo1[hit] : m_lo0[hit];
      pa = {lo[25:6], va[11:0]};
      invalid = en & ~lo[1];
      modify  = en & lo[1] & ~lo[2] & wen;
    end
  endfunction

  function automatic void model_op();
    int i;
    int hit;
    i = int'(bus.cp0_index_r2t[INDEX_W-1:0]);
    if (bus.op_tlbwi_r2t) begin
      m_vpn2[i] = bus.cp0_entryhi_r2t[31:13];
      m_asid[i] = bus.cp0_entryhi_r2t[7:0];
      m_g[i]    = bus.cp0_entrylo0_r2t[0] & bus.cp0_entrylo1_r2t[0];
      m_lo0[i]  = bus.cp0_entrylo0_r2t;
      m_lo1[i]  = bus.cp0_entrylo1_r2t;
    end else if (bus.op_tlbr_r2t) begin
      exp_hi  = {m_vpn2[i], 5'b0, m_asid[i]};
      exp_lo0 = {6'b0, m_lo0[i][25:1], m_g[i]};
      exp_lo1 = {6'b0, m_lo1[i][25:1], m_g[i]};
    end else if (bus.op_tlbp_r2t) begin
      hit = model_lookup(bus.cp0_entryhi_r2t[31:13], bus.cp0_entryhi_r2t[7:0]);
      exp_index = (hit < 0) ? 32'h8000_0000 : 32'(hit);
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] index, input logic [31:0] hi,
                                input logic [31:0] lo0, input logic [31:0] lo1,
                                input logic p, input logic r, input logic wi,
                                input logic i_en, input logic [31:0] i_va,
                                input logic d_en, input logic d_wen, input logic [31:0] d_va);
    bus.cp0_index_r2t    = index;
    bus.cp0_entryhi_r2t  = hi;
    bus.cp0_entrylo0_r2t = lo0;
    bus.cp0_entrylo1_r2t = lo1;
    bus.op_tlbp_r2t      = p;
    bus.op_tlbr_r2t      = r;
    bus.op_tlbwi_r2t     = wi;
    bus.inst_en          = i_en;
    bus.inst_vaddr       = i_va;
    bus.data_en          = d_en;
    bus.data_wen         = d_wen;
    bus.data_vaddr       = d_va;
  endtask

  // Combinational outputs are sampled mid-cycle against the pre-edge model contents.
  task automatic settle_check();
    logic [31:0] pa;
    logic rf, iv, md;
    @(negedge clk);
    model_xlate(bus.inst_vaddr, bus.inst_en, 1'b0, pa, rf, iv, md);
    check_output("inst_paddr", bus.inst_paddr, pa);
    check_output("i_refill", 32'(bus.i_refill_t2r), 32'(rf));
    check_output("i_invalid", 32'(bus.i_invalid_t2r), 32'(iv));
    model_xlate(bus.data_vaddr, bus.data_en, bus.data_wen, pa, rf, iv, md);
    check_output("data_paddr", bus.data_paddr, pa);
    check_output("d_refill", 32'(bus.d_refill_t2r), 32'(rf));
    check_output("d_invalid", 32'(bus.d_invalid_t2r), 32'(iv));
    check_output("d_modify", 32'(bus.d_modify_t2r), 32'(md));
  endtask

  task automatic commit();
    model_op();
    @(posedge clk);
    #1;
    check_output("tlb_index", bus.tlb_index_t2r, exp_index);
    check_output("tlb_entryhi", bus.tlb_entryhi_t2r, exp_hi);
    check_output("tlb_entrylo0", bus.tlb_entrylo0_t2r, exp_lo0);
    check_output("tlb_entrylo1", bus.tlb_entrylo1_t2r, exp_lo1);
    bus.op_tlbp_r2t  = 1'b0;
    bus.op_tlbr_r2t  = 1'b0;
    bus.op_tlbwi_r2t = 1'b0;
  endtask

  logic [18:0] vpn_pool [4];
  logic [7:0]  asid_pool [3];

  initial begin
    vpn_pool  = '{19'h00200, 19'h00201, 19'h7FF00, 19'h40000};
    asid_pool = '{8'h05, 8'h06, 8'h07};
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    #2 rst = 1'b0;
    #1;
    check_output("reset_index", bus.tlb_index_t2r, 32'h0);
    check_output("reset_entryhi", bus.tlb_entryhi_t2r, 32'h0);
    check_output("reset_entrylo0", bus.tlb_entrylo0_t2r, 32'h0);
    check_output("reset_entrylo1", bus.tlb_entrylo1_t2r, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0000, 0, 0, 0);
    settle_check();
    check_output("dir_i_refill", 32'(bus.i_refill_t2r), 32'd1);
    check_output("dir_i_invalid", 32'(bus.i_invalid_t2r), 32'd0);
    commit();

    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_1234, 0, 0, 0);
    settle_check();
    check_output("dir_unmapped_refill", 32'(bus.i_refill_t2r), 32'd0);
    check_output("dir_unmapped_pa", bus.inst_paddr, 32'h0000_1234);
    commit();

    apply_stimulus(3, 32'h0040_0005, 32'h0000_1046, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    settle_check();
    commit();

    apply_stimulus(3, 32'h0040_0005, 32'h0000_1046, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0ABC);
    settle_check();
    check_output("dir_even_pa", bus.data_paddr, 32'h0004_1ABC);
    check_output("dir_even_flags",
                 32'({bus.d_refill_t2r, bus.d_invalid_t2r, bus.d_modify_t2r}), 32'd0);
    commit();

    apply_stimulus(3, 32'h0040_0005, 32'h0000_1046, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0040_1000);
    settle_check();
    check_output("dir_odd_invalid", 32'(bus.d_invalid_t2r), 32'd1);
    commit();

    apply_stimulus(3, 32'h0040_0005, 32'h0000_1046, 32'h0000_1082, 0, 0, 1, 0, 0, 0, 0, 0);
    settle_check();
    commit();

    apply_stimulus(3, 32'h0040_0005, 32'h0000_1046, 32'h0000_1082, 0, 0, 0,
                   0, 0, 1, 1, 32'h0040_1000);
    settle_check();
    check_output("dir_modify", 32'(bus.d_modify_t2r), 32'd1);
    check_output("dir_modify_invalid", 32'(bus.d_invalid_t2r), 32'd0);
    commit();

    apply_stimulus(0, 32'h0040_0005, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    settle_check();
    commit();
    check_output("dir_tlbp_hit", bus.tlb_index_t2r, 32'h0000_0003);

    apply_stimulus(0, 32'h0040_0006, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    settle_check();
    commit();
    check_output("dir_tlbp_miss", bus.tlb_index_t2r, 32'h8000_0000);

    apply_stimulus(3, 32'h0040_0006, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    settle_check();
    commit();
    check_output("dir_tlbr_hi", bus.tlb_entryhi_t2r, 32'h0040_0005);
    check_output("dir_tlbr_lo0", bus.tlb_entrylo0_t2r, 32'h0000_1046);
    check_output("dir_tlbr_lo1", bus.tlb_entrylo1_t2r, 32'h0000_1082);

    // Asynchronous reset lands between edges, just after a write.
    apply_stimulus(5, 32'h0040_0005, 32'h0000_1046, 32'h0000_1082, 0, 0, 1, 0, 0, 0, 0, 0);
    settle_check();
    commit();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_output("midrst_index", bus.tlb_index_t2r, 32'h0);
    check_output("midrst_entryhi", bus.tlb_entryhi_t2r, 32'h0);
    check_output("midrst_entrylo0", bus.tlb_entrylo0_t2r, 32'h0);
    check_output("midrst_entrylo1", bus.tlb_entrylo1_t2r, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(0, 32'h0040_0005, 0, 0, 1, 0, 0, 1, 32'h0040_0000, 0, 0, 0);
    settle_check();
    commit();
    check_output("postrst_tlbp", bus.tlb_index_t2r, 32'h8000_0000);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] hi, idx, lo0, lo1, iva, dva;
      logic [2:0]  ops;
      hi  = {vpn_pool[$urandom_range(0, 3)], 5'($urandom), asid_pool[$urandom_range(0, 2)]};
      idx = {$urandom} & 32'hFFFF_FFF0 | 32'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                                                        : $urandom_range(0, 3));
      lo0 = $urandom;
      lo1 = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        lo0[0] = 1'b1;
        lo1[0] = 1'b1;
      end
      ops = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      iva = {vpn_pool[$urandom_range(0, 3)], 13'($urandom)};
      dva = {vpn_pool[$urandom_range(0, 3)], 13'($urandom)};
      apply_stimulus(idx, hi, lo0, lo1, ops[0], ops[1], ops[2],
                     1'($urandom), iva, 1'($urandom), 1'($urandom), dva);
      settle_check();
      commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
